// File: rtl/risc_ctrl_pkg.sv
// ============================================================================
// Package : risc_ctrl_pkg
// Purpose : Shared types and constants for the multicycle RISC controller
//           step sequencer: the sequencer state enum, the opcode fields that
//           the sequencer decodes itself (OutR, HLT), and the counter ceiling.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_OUT_WAIT = 3'd2,
    ST_HALT     = 3'd3,
    ST_ERR      = 3'd4
  } seq_state_t;

  // System-class major opcode and the two sub-functions handled here
  localparam logic [4:0] OP_SYS   = 5'b11100;
  localparam logic [1:0] SUB_OUTR = 2'b00;
  localparam logic [1:0] SUB_HLT  = 2'b01;

  // Step counter ceiling for the default 3-bit counter
  localparam int CNT_W_DEFAULT = 3;
  localparam int CNT_MAX       = (1 << CNT_W_DEFAULT) - 1;

endpackage : risc_ctrl_pkg

`default_nettype wire

// File: rtl/multicycle_step_seq_step_cnt.sv
// ============================================================================
// Module  : step_cnt
// Purpose : Step counter for the sequencer. Clear has priority over
//           increment; with neither asserted the count holds.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset (count -> 0)
//           clr    - synchronous clear to 0
//           inc    - synchronous increment (modulo 2^W)
//           cnt    - current count
//           at_max - count is all ones
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module step_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == {W{1'b1}});

endmodule : step_cnt

`default_nettype wire

// File: rtl/multicycle_step_seq.sv
// ============================================================================
// Module  : multicycle_step_seq
// Purpose : Step sequencer for the multicycle RISC controller. Produces the
//           step count Cnt, latches the instruction register at step 0,
//           restarts the count on Buff_PC (advancing the PC), stalls on
//           MemWait, runs the OutR output handshake, halts on HLT and trips
//           a sticky error when the count reaches its maximum without an
//           end-of-instruction indication.
// Ports   : clk       - rising-edge clock
//           Rst_n     - asynchronous active-low reset
//           Start     - leave IDLE or HALT
//           MemWait   - memory not ready; freezes the sequencer in RUN
//           Ins       - instruction word, sampled at Cnt==0
//           Buff_PC   - end-of-instruction from the external decoder
//           Out_Ack   - output port accepted Out_Valid
//           Cnt       - current step
//           InsM      - IR[15:11]
//           InsL      - IR[1:0]
//           PC_Wr     - PC advance strobe (combinational)
//           Out_Valid - OutR data available
//           Halted    - sequencer is in HALT
//           Err       - watchdog tripped, sticky until reset
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_step_seq
  import risc_ctrl_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int IW    = 16
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             MemWait,
  input  logic [IW-1:0]    Ins,
  input  logic             Buff_PC,
  input  logic             Out_Ack,
  output logic [CNT_W-1:0] Cnt,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic             PC_Wr,
  output logic             Out_Valid,
  output logic             Halted,
  output logic             Err
);

  seq_state_t state, state_nxt;

  logic [IW-1:0] ir;
  logic          ir_ld;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          cnt_at_max;
  logic          out_valid_nxt;
  logic          halted_nxt;
  logic          err_nxt;

  // --------------------------------------------------------------------------
  // Step counter
  // --------------------------------------------------------------------------
  step_cnt #(
    .W (CNT_W)
  ) u_step_cnt (
    .clk    (clk),
    .rst_n  (Rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (Cnt),
    .at_max (cnt_at_max)
  );

  // --------------------------------------------------------------------------
  // Instruction register fields
  // --------------------------------------------------------------------------
  assign InsM = ir[IW-1 -: 5];
  assign InsL = ir[1:0];

  // The middle IR bits are consumed by the datapath decoder, not here.
  logic unused_ir_mid;
  assign unused_ir_mid = ^ir[IW-6:2];

  logic cnt_is_0;
  logic cnt_is_1;
  logic dec_hlt;
  logic dec_outr;

  assign cnt_is_0 = (Cnt == CNT_W'(0));
  assign cnt_is_1 = (Cnt == CNT_W'(1));
  assign dec_hlt  = (InsM == OP_SYS) && (InsL == SUB_HLT);
  assign dec_outr = (InsM == OP_SYS) && (InsL == SUB_OUTR);

  // PC only advances on an un-stalled end-of-instruction while running.
  assign PC_Wr = (state == ST_RUN) && Buff_PC && !MemWait;

  // --------------------------------------------------------------------------
  // State register and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      ir        <= '0;
      Out_Valid <= 1'b0;
      Halted    <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      Out_Valid <= out_valid_nxt;
      Halted    <= halted_nxt;
      Err       <= err_nxt;
      if (ir_ld) begin
        ir <= Ins;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    ir_ld         = 1'b0;
    out_valid_nxt = Out_Valid;
    halted_nxt    = Halted;
    err_nxt       = Err;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // A stall freezes count, IR and state alike.
        if (!MemWait) begin
          ir_ld = cnt_is_0;
          if (Buff_PC) begin
            // End-of-instruction wins over the HLT/OutR decode at step 1.
            cnt_clr = 1'b1;
          end else if (cnt_is_1 && dec_hlt) begin
            state_nxt  = ST_HALT;
            cnt_clr    = 1'b1;
            halted_nxt = 1'b1;
          end else if (cnt_is_1 && dec_outr) begin
            // Count stays at 1 for the whole handshake.
            state_nxt     = ST_OUT_WAIT;
            out_valid_nxt = 1'b1;
          end else if (cnt_at_max) begin
            // Decoder never ended the instruction: trip the watchdog and
            // leave the count frozen at its maximum.
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_OUT_WAIT: begin
        // MemWait is deliberately ignored during the handshake.
        if (Out_Ack) begin
          state_nxt     = ST_RUN;
          out_valid_nxt = 1'b0;
          cnt_inc       = 1'b1;
        end
      end

      ST_HALT: begin
        if (Start) begin
          state_nxt  = ST_RUN;
          halted_nxt = 1'b0;
        end
      end

      ST_ERR: begin
        state_nxt = ST_ERR;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : multicycle_step_seq

`default_nettype wire

// File: tb/tb_multicycle_step_seq.sv
// ============================================================================
// Module  : tb_multicycle_step_seq
// Purpose : Self-checking bench for multicycle_step_seq. A stimulus process
//           drives one cycle at a time, advances a behavioural model and
//           queues the outputs expected before the next edge; a monitor
//           pops and compares them shortly before that edge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_step_seq;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic        MemWait;
  logic [15:0] Ins;
  logic        Buff_PC;
  logic        Out_Ack;
  logic [2:0]  Cnt;
  logic [4:0]  InsM;
  logic [1:0]  InsL;
  logic        PC_Wr;
  logic        Out_Valid;
  logic        Halted;
  logic        Err;

  always #5 clk = ~clk;

  multicycle_step_seq #(
    .CNT_W (3),
    .IW    (16)
  ) dut (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .MemWait   (MemWait),
    .Ins       (Ins),
    .Buff_PC   (Buff_PC),
    .Out_Ack   (Out_Ack),
    .Cnt       (Cnt),
    .InsM      (InsM),
    .InsL      (InsL),
    .PC_Wr     (PC_Wr),
    .Out_Valid (Out_Valid),
    .Halted    (Halted),
    .Err       (Err)
  );

  // ---------------------------------------------------------------------------
  // Stub end-of-instruction decoder: step at which each instruction ends.
  // ---------------------------------------------------------------------------
  bit stub_dead;

  function automatic logic stub_buff(input logic [2:0] c, input logic [4:0] m,
                                     input logic [1:0] l, input bit dead);
    if (dead) return 1'b0;
    case (m)
      5'b00111: return (c == 3'd3);           // ADDI: 4 steps
      5'b01000: return (c == 3'd2);           // JMP : 3 steps
      5'b11100: begin
        if (l == 2'b00) return (c == 3'd3);   // OutR ends after handshake
        if (l == 2'b01) return 1'b0;          // HLT never ends normally
        return (c == 3'd1);
      end
      5'b11111: return 1'b0;
      default:  return (c == 3'(1 + m[1:0]));
    endcase
  endfunction

  assign Buff_PC = stub_buff(Cnt, InsM, InsL, stub_dead);

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_cnt;
  logic [15:0] m_ir;
  bit          m_run;    // fetching/executing (includes the handshake)
  bit          m_outw;   // waiting for Out_Ack
  bit          m_halt;
  bit          m_err;

  typedef struct packed {
    logic [2:0] cnt;
    logic [4:0] insm;
    logic [1:0] insl;
    logic       pc_wr;
    logic       ov;
    logic       halted;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic model_reset();
    m_cnt  = 0;
    m_ir   = 16'h0000;
    m_run  = 0;
    m_outw = 0;
    m_halt = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit st, input bit mw, input bit ack,
                            input logic [15:0] ins, input bit buff);
    if (m_err) begin
      // only reset leaves the error condition
    end else if (m_halt) begin
      if (st) begin
        m_halt = 0;
        m_run  = 1;
      end
    end else if (m_outw) begin
      if (ack) begin
        m_outw = 0;
        m_cnt  = 2;
      end
    end else if (m_run) begin
      if (!mw) begin
        if (m_cnt == 0) m_ir = ins;
        if (buff) begin
          m_cnt = 0;
        end else if (m_cnt == 1 && m_ir[15:11] == 5'b11100 && m_ir[1:0] == 2'b01) begin
          m_halt = 1;
          m_run  = 0;
          m_cnt  = 0;
        end else if (m_cnt == 1 && m_ir[15:11] == 5'b11100 && m_ir[1:0] == 2'b00) begin
          m_outw = 1;
        end else if (m_cnt == 7) begin
          m_err = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end else if (st) begin
      m_run = 1;
    end
  endtask

  // One clock cycle of stimulus: drive, predict, advance the model.
  task automatic cycle(input bit rstn, input bit st, input bit mw, input bit ack,
                       input logic [15:0] ins);
    exp_t e;
    bit   buff;
    @(negedge clk);
    Rst_n   = rstn;
    Start   = st;
    MemWait = mw;
    Out_Ack = ack;
    Ins     = ins;
    #1;
    if (!rstn) model_reset();
    buff     = stub_buff(3'(m_cnt), m_ir[15:11], m_ir[1:0], stub_dead);
    e.cnt    = 3'(m_cnt);
    e.insm   = m_ir[15:11];
    e.insl   = m_ir[1:0];
    e.pc_wr  = m_run && !m_outw && !m_err && buff && !mw;
    e.ov     = m_outw;
    e.halted = m_halt;
    e.err    = m_err;
    exp_q.push_back(e);
    if (rstn) model_step(st, mw, ack, ins, buff);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("Cnt",       8'(Cnt),       8'(e.cnt));
        chk("InsM",      8'(InsM),      8'(e.insm));
        chk("InsL",      8'(InsL),      8'(e.insl));
        chk("PC_Wr",     8'(PC_Wr),     8'(e.pc_wr));
        chk("Out_Valid", 8'(Out_Valid), 8'(e.ov));
        chk("Halted",    8'(Halted),    8'(e.halted));
        chk("Err",       8'(Err),       8'(e.err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    logic [15:0] ins;
    int          ow;
    int          stalls;
    Rst_n = 1'b0; Start = 1'b0; MemWait = 1'b0; Out_Ack = 1'b0; Ins = 16'h0;
    stub_dead = 0;
    model_reset();

    // Reset and start, then reset again mid-instruction at Cnt==3
    cycle(0, 0, 0, 0, 16'h3800);
    cycle(0, 0, 0, 0, 16'h3800);
    cycle(1, 1, 0, 0, 16'h3800);
    for (int i = 0; i < 20 && m_cnt != 3; i++) cycle(1, 0, 0, 0, 16'h3800);
    cycle(0, 0, 0, 0, 16'h3800);
    cycle(0, 0, 0, 0, 16'h3800);
    cycle(1, 1, 0, 0, 16'h3800);
    cycle(1, 0, 0, 0, 16'h3800);
    cycle(1, 0, 0, 0, 16'h3800);

    // Variable length: ADDI (4 steps) then JMP (3 steps)
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 16'h3800);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 16'h4000);

    // Stall at Cnt==2 with Buff_PC pending on a JMP
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_cnt == 2 && m_ir[15:11] == 5'b01000 && stalls < 3) begin
        stalls++;
        cycle(1, 0, 1, 0, 16'h4000);
      end else begin
        cycle(1, 0, 0, 0, 16'h4000);
      end
    end

    // OutR handshake with a delayed acknowledge
    ow = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_outw) ow++;
      cycle(1, 0, $urandom_range(0, 1) == 1, m_outw && ow >= 4, 16'hE000);
    end

    // HLT, hold 10 cycles, restart
    for (int i = 0; i < 20 && !m_halt; i++) cycle(1, 0, 0, 0, 16'hE001);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 16'h3800);
    cycle(1, 1, 0, 0, 16'h3800);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 16'h3800);

    // Watchdog: decoder never ends the instruction
    stub_dead = 1;
    for (int i = 0; i < 14; i++) cycle(1, i[0], 0, 0, 16'h3800);
    cycle(0, 0, 0, 0, 16'h3800);
    stub_dead = 0;
    cycle(1, 1, 0, 0, 16'h3800);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 5))
        0:       ins = 16'h3800;
        1:       ins = 16'h4000;
        2:       ins = 16'hE000;
        3:       ins = 16'hE001;
        4:       ins = 16'hE002;
        default: ins = {5'($urandom_range(0, 27)), 11'($urandom)};
      endcase
      cycle($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 40,
            ins);
    end

    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multicycle_step_seq

`default_nettype wire
